// File: rtl/ipbase_pkg.sv
// Shared constants and helpers for the ipbase_* FIFO-side blocks.
package ipbase_pkg;

    localparam int RD_LATENCY_MAX = 4;

    function automatic int clog2(input int value);
        for (int w = 0; w < 32; w++) begin
            if ((1 << w) >= value) return w;
        end
        return 32;
    endfunction

endpackage

// File: rtl/ipbase_catch_buf.sv
// Circular register buffer that catches FIFO read data; depth need not be a power of 2.
module ipbase_catch_buf
    import ipbase_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int BUF_DEPTH  = 3,
    parameter int CNT_WIDTH  = clog2(BUF_DEPTH + 1)
) (
    input  logic                  wr_clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [CNT_WIDTH-1:0]  o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int                   PTR_WIDTH = (BUF_DEPTH > 1) ? clog2(BUF_DEPTH) : 1;
    localparam logic [CNT_WIDTH-1:0] DEPTH_C   = CNT_WIDTH'(BUF_DEPTH);
    localparam logic [PTR_WIDTH-1:0] LAST_PTR  = PTR_WIDTH'(BUF_DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
    logic [PTR_WIDTH-1:0]  r_wptr;
    logic [PTR_WIDTH-1:0]  r_rptr;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  w_push_ok;
    logic                  w_pop_ok;

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign o_full    = (r_count == DEPTH_C);
    assign o_empty   = (r_count == '0);
    // A push into a full buffer is only taken when a pop frees a slot in the same cycle.
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= ptr_inc(r_wptr);
            if (w_pop_ok)  r_rptr <= ptr_inc(r_rptr);
            if (w_push_ok && !w_pop_ok)      r_count <= r_count + 1'b1;
            else if (!w_push_ok && w_pop_ok) r_count <= r_count - 1'b1;
        end
    end

    // NOTE: storage is not reset; the count gates visibility, so stale contents never leak out.
    always_ff @(posedge wr_clk) begin
        if (w_push_ok) r_mem[r_wptr] <= i_data;
    end

    assign o_data  = o_empty ? '0 : r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/ipbase_fifo_rd_stream.sv
// FIFO read engine: credit-limited pops, latency tracking, and a catch buffer presented as valid/ready.
module ipbase_fifo_rd_stream
    import ipbase_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = RD_LATENCY + 2,
    parameter int CNT_WIDTH  = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  wr_clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic                  fifo_rd_busy,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  buf_count,
    output logic                  err_ovf
);

    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(BUF_DEPTH);

    if (RD_LATENCY < 1 || RD_LATENCY > RD_LATENCY_MAX || BUF_DEPTH < RD_LATENCY + 2) begin : g_bad_params
        $error("ipbase_fifo_rd_stream: illegal RD_LATENCY/BUF_DEPTH combination");
    end

    logic [CNT_WIDTH-1:0]  r_pending;
    logic [RD_LATENCY-1:0] r_vld_pipe;
    logic                  r_err_ovf;
    logic                  w_issue;
    logic                  w_handshake;
    logic                  w_capture;
    logic                  w_buf_full;
    logic                  w_buf_empty;

    // Credits cover in-flight reads plus buffered words, so every issued read has a slot waiting.
    assign w_issue     = !rst && !fifo_empty && !fifo_rd_busy && (r_pending < DEPTH_C);
    assign fifo_rd_en  = w_issue;
    assign w_handshake = m_valid && m_ready;
    assign w_capture   = r_vld_pipe[RD_LATENCY-1];
    assign m_valid     = !w_buf_empty;
    assign err_ovf     = r_err_ovf;

    // NOTE: reset is synchronous and active-high to match the FIFO read-side domain.
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            r_pending  <= '0;
            r_vld_pipe <= '0;
            r_err_ovf  <= 1'b0;
        end else begin
            r_vld_pipe <= RD_LATENCY'({r_vld_pipe, w_issue});
            unique case ({w_issue, w_handshake})
                2'b10:   r_pending <= r_pending + 1'b1;
                2'b01:   r_pending <= r_pending - 1'b1;
                default: r_pending <= r_pending;
            endcase
            if (w_capture && w_buf_full && !w_handshake) r_err_ovf <= 1'b1;
        end
    end

    ipbase_catch_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_catch_buf (
        .wr_clk  (wr_clk),
        .rst     (rst),
        .i_push  (w_capture),
        .i_data  (fifo_dout),
        .i_pop   (w_handshake),
        .o_data  (m_data),
        .o_count (buf_count),
        .o_full  (w_buf_full),
        .o_empty (w_buf_empty)
    );

    a_no_wrap : assert property (@(posedge wr_clk) disable iff (rst)
        (r_pending <= DEPTH_C) && (buf_count <= DEPTH_C));

endmodule

// File: tb/tb_ipbase_fifo_rd_stream.sv
// Scoreboard bench for ipbase_fifo_rd_stream with a latency-2 FIFO model and a 4-entry buffer.
module tb_ipbase_fifo_rd_stream;

    localparam int DW    = 16;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic          wr_clk       = 1'b0;
    logic          rst          = 1'b1;
    logic          fifo_empty   = 1'b1;
    logic          fifo_rd_busy = 1'b0;
    logic          m_ready      = 1'b1;
    logic [DW-1:0] fifo_dout    = '0;
    logic [DW-1:0] dout_s0      = '0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [CW-1:0] buf_count;
    logic          err_ovf;

    logic [DW-1:0] fifo_q [$];
    exp_t          sb [$];
    int            cyc      = 0;
    int            n_pops   = 0;
    int            n_hs     = 0;
    int            n_checks = 0;
    int            n_fail   = 0;
    bit            chk_lat  = 1'b1;

    always #5 wr_clk = ~wr_clk;

    ipbase_fifo_rd_stream #(
        .DATA_WIDTH (DW),
        .RD_LATENCY (LAT),
        .BUF_DEPTH  (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .wr_clk       (wr_clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_busy (fifo_rd_busy),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_dout    (fifo_dout),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .buf_count    (buf_count),
        .err_ovf      (err_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // FIFO model: pop on the edge, data emerges two cycles later; empty flag is registered.
    always @(posedge wr_clk) begin
        logic [DW-1:0] w;
        w = 16'hBAD0;
        if (fifo_rd_en) begin
            w = fifo_q.pop_front();
            sb.push_back('{w, cyc});
            n_pops++;
        end
        if (rst) sb.delete();
        dout_s0    <= w;
        fifo_dout  <= dout_s0;
        fifo_empty <= (fifo_q.size() == 0);
        cyc++;
    end

    // Stream monitor: every handshake is checked against the scoreboard head.
    always @(negedge wr_clk) begin
        exp_t e;
        if (!rst && m_valid && m_ready) begin
            n_hs++;
            check("sb_has_entry", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("stream_data", 32'(m_data), 32'(e.data));
                if (chk_lat) check("issue_to_beat", 32'(cyc - e.cyc), LAT + 1);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge wr_clk);
    endtask

    task automatic drain(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge wr_clk);
            done = (fifo_q.size() == 0) && (sb.size() == 0) && !m_valid;
        end
        check(tag, 32'(done), 1);
    endtask

    initial begin
        int pops0;
        int hs0;

        // 1: reset with the FIFO pre-loaded
        for (int i = 1; i <= 8; i++) fifo_q.push_back(DW'(i));
        for (int i = 0; i < 3; i++) begin
            @(negedge wr_clk);
            check("rst_rd_en", 32'(fifo_rd_en), 0);
            check("rst_valid", 32'(m_valid), 0);
            check("rst_count", 32'(buf_count), 0);
            check("rst_err", 32'(err_ovf), 0);
        end
        rst = 1'b0;

        // 2: full-rate streaming; first issue is cycle t, k is the offset from t
        for (int k = 1; k <= 11; k++) begin
            @(negedge wr_clk);
            if (k == 1) begin
                check("post_rst_count", 32'(buf_count), 0);
                check("post_rst_err", 32'(err_ovf), 0);
            end
            check("t2_valid", 32'(m_valid), 32'(k >= 3 && k <= 10));
            if (k >= 3 && k <= 10) check("t2_data", 32'(m_data), 32'(k - 2));
            check("t2_rd_en", 32'(fifo_rd_en), 32'(k <= 7));
        end

        // 3: backpressure, buffer fills to depth and holds the head word
        m_ready = 1'b0;
        chk_lat = 1'b0;
        pops0   = n_pops;
        hs0     = n_hs;
        for (int i = 0; i < 10; i++) fifo_q.push_back(DW'(16'h0101 + i));
        step(12);
        check("t3_pops", 32'(n_pops - pops0), DEPTH);
        check("t3_count", 32'(buf_count), DEPTH);
        check("t3_valid", 32'(m_valid), 1);
        check("t3_head", 32'(m_data), 32'h0101);
        check("t3_rd_en", 32'(fifo_rd_en), 0);
        step(3);
        check("t3_head_stable", 32'(m_data), 32'h0101);
        m_ready = 1'b1;
        drain("t3_drain", 60);
        check("t3_delivered", 32'(n_hs - hs0), 10);
        check("t3_err", 32'(err_ovf), 0);
        chk_lat = 1'b1;

        // 4: sparse source, one word every third cycle
        for (int j = 0; j <= 6; j++) begin
            if (j < 6) fifo_q.push_back(DW'(16'h0401 + j));
            for (int k = 1; k <= 3; k++) begin
                @(negedge wr_clk);
                if (k == 1) begin
                    check("t4_valid", 32'(m_valid), 32'(j > 0));
                    if (j > 0) check("t4_data", 32'(m_data), 32'(16'h0401 + j - 1));
                    check("t4_rd_en", 32'(fifo_rd_en), 32'(j < 6));
                end else begin
                    check("t4_gap", 32'(m_valid), 0);
                end
            end
        end

        // 5: rd_rst_busy blocks issue while two reads are in flight
        hs0 = n_hs;
        for (int i = 0; i < 6; i++) fifo_q.push_back(DW'(16'h0501 + i));
        step(3);
        fifo_rd_busy = 1'b1;
        pops0 = n_pops;
        for (int i = 0; i < 5; i++) begin
            @(negedge wr_clk);
            check("t5_rd_en_blocked", 32'(fifo_rd_en), 0);
        end
        check("t5_no_pops", 32'(n_pops - pops0), 0);
        check("t5_inflight_delivered", 32'(n_hs - hs0), 2);
        fifo_rd_busy = 1'b0;
        drain("t5_drain", 40);
        check("t5_delivered", 32'(n_hs - hs0), 6);

        // 6: reset with one word buffered and two in flight
        m_ready = 1'b0;
        pops0   = n_pops;
        for (int i = 0; i < 5; i++) fifo_q.push_back(DW'(16'h0601 + i));
        step(4);
        check("t6_pops_before_rst", 32'(n_pops - pops0), 3);
        check("t6_count_before_rst", 32'(buf_count), 1);
        check("t6_head_before_rst", 32'(m_data), 32'h0601);
        rst = 1'b1;
        step(1);
        check("t6_rst_valid", 32'(m_valid), 0);
        check("t6_rst_count", 32'(buf_count), 0);
        check("t6_rst_rd_en", 32'(fifo_rd_en), 0);
        step(1);
        rst     = 1'b0;
        m_ready = 1'b1;
        hs0     = n_hs;
        drain("t6_drain", 40);
        check("t6_delivered", 32'(n_hs - hs0), 2);
        check("t6_err", 32'(err_ovf), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
